// File: rtl/press_arbiter.sv
// press_arbiter
// -----------------------------------------------------------------------------
// Shares one game-logic consumer among N player push-buttons. Each button is
// edge-detected, every press is latched as a pending request, and pending
// requests are granted one at a time in round-robin order over a valid/ack
// handshake. Presses that arrive while another press is being served are
// held in the pending register, never lost.
//
// Optional feature macro: PRESS_ARB_HOLDOFF_EN
//    When defined, an ack is followed by a HOLD phase of exactly HOLDOFF
//    cycles. During HOLD no grant is offered and new presses from the player
//    that was just served are discarded (other players still latch).
//    When undefined, HOLDOFF is ignored and an ack returns straight to IDLE.
//
// Parameters:
//    N        number of players/buttons (2..16)
//    HOLDOFF  hold-off length in cycles (>=1), used only with the macro
//
// Ports:
//    clk          clock
//    reset        synchronous, active-high reset
//    btn[N]       button levels, already synchronized to clk, 1 = pressed
//    grant_ack    consumer accepts the grant currently offered
//    grant_valid  a grant is being offered (registered)
//    grant_id     index of the granted player (registered)
//    pending[N]   latched presses not yet served (registered)
// -----------------------------------------------------------------------------
module press_arbiter #(
   parameter int N       = 4,
   parameter int HOLDOFF = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         btn,
   input  logic                 grant_ack,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_id,
   output logic [N-1:0]         pending
);

   localparam int IW = $clog2(N);

`ifdef PRESS_ARB_HOLDOFF_EN
   localparam int CW = $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {
      IDLE,
      OFFER,
      HOLD
   } state_t;
`else
   typedef enum logic {
      IDLE,
      OFFER
   } state_t;
`endif

   state_t          r_state;
   state_t          w_nextState;

   logic [N-1:0]    r_prev;
   logic [N-1:0]    r_pending;
   logic            r_grantValid;
   logic [IW-1:0]   r_grantId;
   logic [IW-1:0]   r_ptr;

   logic [N-1:0]    w_edge;
   logic [N-1:0]    w_ackClear;
   logic            w_rrHit;
   logic [IW-1:0]   w_rrId;
   logic [IW-1:0]   w_scanIdx;
   logic            w_nextGrantValid;
   logic [IW-1:0]   w_nextGrantId;
   logic [IW-1:0]   w_nextPtr;

`ifdef PRESS_ARB_HOLDOFF_EN
   logic [CW-1:0]   r_holdCnt;
   logic [CW-1:0]   w_nextHoldCnt;
`endif

   // Rising-edge detection against the previous button sample. While holding
   // off, presses from the player that was just served are thrown away so a
   // bouncing or hammered button cannot immediately re-queue itself.
   always_comb begin
      w_edge = btn & ~r_prev;
`ifdef PRESS_ARB_HOLDOFF_EN
      if (r_state == HOLD) begin
         w_edge[r_ptr] = 1'b0;
      end
`endif
   end

   // One-hot mask of the request being retired by an accepted grant. The ack
   // only counts while an offer is actually outstanding.
   always_comb begin
      w_ackClear = '0;
      if ((r_state == OFFER) && grant_ack) begin
         w_ackClear[r_grantId] = 1'b1;
      end
   end

   // Round-robin search: start just after the last served player and take
   // the first pending bit found, wrapping around the player range. Because
   // k runs 1..N, the last player checked is the previous winner itself.
   always_comb begin
      w_rrHit   = 1'b0;
      w_rrId    = '0;
      w_scanIdx = '0;
      for (int k = 1; k <= N; k++) begin
         w_scanIdx = IW'((int'(r_ptr) + k) % N);
         if (!w_rrHit && r_pending[w_scanIdx]) begin
            w_rrHit = 1'b1;
            w_rrId  = w_scanIdx;
         end
      end
   end

   // Next-state and next-output logic for the grant FSM. Everything holds
   // its value by default; grant_id only moves on the IDLE to OFFER step so
   // the consumer sees a stable index for the whole offer.
   always_comb begin
      w_nextState      = r_state;
      w_nextGrantValid = r_grantValid;
      w_nextGrantId    = r_grantId;
      w_nextPtr        = r_ptr;
`ifdef PRESS_ARB_HOLDOFF_EN
      w_nextHoldCnt    = r_holdCnt;
`endif
      case (r_state)
         IDLE: begin
            if (w_rrHit) begin
               w_nextState      = OFFER;
               w_nextGrantValid = 1'b1;
               w_nextGrantId    = w_rrId;
            end
         end
         OFFER: begin
            if (grant_ack) begin
               w_nextGrantValid = 1'b0;
               w_nextPtr        = r_grantId;
`ifdef PRESS_ARB_HOLDOFF_EN
               w_nextState      = HOLD;
               w_nextHoldCnt    = CW'(HOLDOFF);
`else
               w_nextState      = IDLE;
`endif
            end
         end
`ifdef PRESS_ARB_HOLDOFF_EN
         HOLD: begin
            // The counter is loaded with HOLDOFF on the ack and leaves on
            // the step that would take it to zero, so HOLD spans exactly
            // HOLDOFF cycles.
            if (r_holdCnt <= CW'(1)) begin
               w_nextState   = IDLE;
               w_nextHoldCnt = '0;
            end else begin
               w_nextHoldCnt = r_holdCnt - CW'(1);
            end
         end
`endif
         default: begin
            w_nextState      = IDLE;
            w_nextGrantValid = 1'b0;
         end
      endcase
   end

   // State and datapath registers. The previous-sample register resets to
   // all-ones so a button already held down through reset is not seen as a
   // fresh press, and the pointer resets to the last player so player 0 has
   // first priority. A new edge on a player wins over its own ack in the
   // same cycle, keeping that request pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_prev       <= '1;
         r_pending    <= '0;
         r_grantValid <= 1'b0;
         r_grantId    <= '0;
         r_ptr        <= IW'(N - 1);
      end else begin
         r_state      <= w_nextState;
         r_prev       <= btn;
         r_pending    <= (r_pending & ~w_ackClear) | w_edge;
         r_grantValid <= w_nextGrantValid;
         r_grantId    <= w_nextGrantId;
         r_ptr        <= w_nextPtr;
      end
   end

`ifdef PRESS_ARB_HOLDOFF_EN
   // Hold-off down-counter, only present when the feature is built in.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_holdCnt <= '0;
      end else begin
         r_holdCnt <= w_nextHoldCnt;
      end
   end
`endif

   assign grant_valid = r_grantValid;
   assign grant_id    = r_grantId;
   assign pending     = r_pending;

endmodule
